parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Serial frame receiver for XOR-parity-protected bytes. It is the receive end of the team's parity-generating serial transmitter.
- Accepts one bit per `rx_valid` strobe and assembles start, data, parity and stop bits into a word.
- Checks parity with a running XOR of the data bits and flags framing errors.
- Sits between the bit-level serial link and the word-level consumer; maintains a saturating error counter for status reads.

Parameters:
- DATA_W, 8, number of data bits per frame, LSB first; legal range 2..16.
- PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit = 0); 1 = odd parity (XOR = 1).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rx_bit, input, 1, serial bit value; sampled only when rx_valid=1.
- rx_valid, input, 1, bit strobe; one bit consumed per clk edge with rx_valid=1.
- data_out, output, DATA_W, last successfully framed word; held until the next good frame.
- data_valid, output, 1, one-cycle pulse when data_out updates.
- parity_err, output, 1, parity result for the word in data_out; held with data_out.
- frame_err, output, 1, one-cycle pulse when the stop bit is sampled as 0.
- busy, output, 1, high while a frame is in progress.
- err_count, output, ERRCNT_W, saturating count of parity errors plus framing errors.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0; shift register, bit counter and XOR accumulator cleared.
- Registered outputs: all outputs are registered.
- State holding: the FSM advances only on edges where rx_valid=1. With rx_valid=0, all state is held and gaps of any length are legal.
- IDLE:
  - rx_valid=1 with rx_bit=0 (start bit) -> DATA; bit counter=0, accumulator=0.
  - rx_valid=1 with rx_bit=1 is idle line and is ignored.
- DATA:
  - Each strobe shifts rx_bit into the shift register, LSB first: bit k lands at position k.
  - Each strobe updates accumulator ^= rx_bit and increments the counter (width $clog2(DATA_W)).
  - On the strobe where counter==DATA_W-1 -> PARITY.
- PARITY:
  - On strobe, compute perr = accumulator ^ rx_bit ^ PARITY_ODD and register it internally -> STOP.
- STOP, on strobe:
  - rx_bit=1:
    - data_out <= shift register, parity_err <= perr.
    - data_valid=1 for exactly one cycle, starting the clock after the stop-bit edge.
    - If perr=1, err_count increments.
  - rx_bit=0:
    - frame_err=1 for one cycle; data_valid stays 0.
    - data_out and parity_err are unchanged; err_count increments.
    - The parity result of the discarded frame is not counted.
  - Either case -> IDLE. The stop bit is never reinterpreted as a start bit.
- busy: 1 in DATA, PARITY and STOP; 0 in IDLE. It deasserts on the same edge that data_valid or frame_err asserts.
- Latency: start bit to data_valid is DATA_W+2 strobes plus one clock.
- Back-to-back frames: a start bit on the strobe immediately after the stop bit is accepted.
- err_count saturation: saturates at 2^ERRCNT_W-1 and never wraps.
- Single-frame error accounting: at most one increment per frame.
- Reset mid-frame: the partial frame is discarded immediately and nothing is emitted. The first start bit after rst_n deasserts begins a fresh frame.
- X handling: rx_bit is don't-care when rx_valid=0 and must not affect state.

Test Plan (DATA_W=8, PARITY_ODD=0):
- Good frame: strobe 0, data bits 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 on consecutive cycles -> data_out=0xA5, data_valid high one cycle, parity_err=0, err_count=0, busy low afterwards.
- Parity error: frame for 0x07 with parity bit 0 -> data_out=0x07, data_valid pulse, parity_err=1, err_count=1.
- Framing error: frame for 0x5A, correct parity 0, stop bit 0 -> frame_err one-cycle pulse, no data_valid, data_out keeps previous 0x07, err_count increments by 1.
- Gapped strobes: frame for 0xA5 with 3 idle cycles (rx_valid=0, rx_bit toggling) between every bit -> identical result to the good-frame case, busy high throughout.
- Reset mid-frame: assert rst_n=0 asynchronously after 4 data bits -> all outputs 0 immediately. Then send a full good frame for 0x3C, parity 0, stop 1 -> data_out=0x3C, parity_err=0.
- Idle and saturation: 20 strobes of rx_bit=1 produce no activity. Then 260 frames with bad parity -> err_count stops at 255.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: LSB-first serial frame receiver with XOR parity check, framing check and saturating error counter
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_bit,
    input  logic                rx_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, data_out_q, data_out_d;
    logic                acc_q, acc_d, perr_q, perr_d;
    logic                data_valid_q, data_valid_d, parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d, busy_q, busy_d, err_inc;
    logic [ERRCNT_W-1:0] err_q, err_d;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_inc      = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: if (!rx_bit) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
                DATA: begin
                    // right shift so the first data bit ends at bit 0
                    shift_d = {rx_bit, shift_q[DATA_W-1:1]};
                    acc_d   = acc_q ^ rx_bit;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(DATA_W - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    perr_d  = acc_q ^ rx_bit ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    state_d      = IDLE;
                    data_out_d   = rx_bit ? shift_q : data_out_q;
                    parity_err_d = rx_bit ? perr_q : parity_err_q;
                    data_valid_d = rx_bit;
                    frame_err_d  = !rx_bit;
                    err_inc      = rx_bit ? perr_q : 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
        err_d  = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign err_count  = err_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: scoreboard bench for parity_frame_rx with DATA_W=8, even parity
module tb_parity_frame_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_bit = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy;
    logic [7:0] err_count;
    typedef struct {
        logic       fe;
        logic [7:0] data;
        logic       perr;
        logic [7:0] ecnt;
    } exp_t;
    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic [7:0] ecnt = 8'h00;
    logic       prev_pulse = 1'b0;
    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy), .err_count(err_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid || frame_err) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("frame_err", frame_err, e.fe);
                    chk("data_valid", data_valid, !e.fe);
                    chk("data_out", data_out, e.data);
                    chk("parity_err", parity_err, e.perr);
                    chk("err_count", err_count, e.ecnt);
                    chk("busy_after", busy, 0);
                end
            end
            if (prev_pulse) chk("pulse_width", data_valid | frame_err, 0);
            prev_pulse <= data_valid | frame_err;
        end else prev_pulse <= 1'b0;
    end
    task automatic send_bit(input logic b, input int gap, input logic bchk);
        for (int i = 0; i <= gap; i++) begin
            @(negedge clk);
            if (bchk) chk("busy_in_frame", busy, 1);
            rx_valid = (i == gap);
            rx_bit   = (i == gap) ? b : i[0];
        end
    endtask
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
        logic perr;
        perr = ^d ^ par;
        if (stop) begin
            last_data = d;
            last_perr = perr;
        end
        if (!stop || perr) ecnt = (ecnt == 8'hFF) ? ecnt : ecnt + 8'd1;
        sb.push_back('{fe: !stop, data: last_data, perr: last_perr, ecnt: ecnt});
        send_bit(1'b0, gap, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b1);
        send_bit(par, gap, 1'b1);
        send_bit(stop, gap, 1'b1);
    endtask
    task automatic wait_done(input logic chk_lat);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 6) begin
            @(negedge clk);
            rx_valid = 1'b0;
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
        if (chk_lat) chk("latency", n, 1);
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_parity_err"}, parity_err, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask
    initial begin
        logic [7:0] p;
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        chk("good_busy_low", busy, 0);
        send_frame(8'h07, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        wait_done(1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        wait_done(1'b1);
        p = 8'h3C;
        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(p[i], 0, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        last_data = 8'h00;
        last_perr = 1'b0;
        ecnt = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        send_frame(8'h81, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        send_frame(8'h6B, 1'b1, 1'b1, 1);
        wait_done(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_bit   = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_data_out", data_out, last_data);
        chk("idle_err_count", err_count, ecnt);
        for (int i = 0; i < 260; i++) send_frame(8'h01, 1'b0, 1'b1, 0);
        wait_done(1'b1);
        chk("err_sat", err_count, 8'hFF);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        wait_done(1'b1);
        chk("err_sat_fe", err_count, 8'hFF);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
